// File: rtl/tex_mem_sched.sv
// tex_mem_sched: sequences one multi-lane texel fetch into word reads on the dcache port and reassembles the texels.
// Define TEX_MEM_SCHED_PERF_EN to add perf_mem_reqs / perf_stall_cycles counters.
module tex_mem_sched #(
  parameter int  NUM_REQS  = 4,
  parameter int  REQ_INFOW = 8,
  localparam int NSLOT     = NUM_REQS * 4,
  localparam int TAGW      = $clog2(NSLOT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [NUM_REQS-1:0]        req_tmask,
  input  logic                       req_filter,
  input  logic [1:0]                 req_lgstride,
  input  logic [NUM_REQS-1:0][31:0]  req_baseaddr,
  input  logic [NSLOT-1:0][31:0]     req_addr,
  input  logic [REQ_INFOW-1:0]       req_info,
  output logic                       req_ready,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [31:0]                mem_req_addr,
  output logic [TAGW-1:0]            mem_req_tag,
  input  logic                       mem_rsp_valid,
  input  logic [31:0]                mem_rsp_data,
  input  logic [TAGW-1:0]            mem_rsp_tag,
  output logic                       mem_rsp_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [NUM_REQS-1:0]        rsp_tmask,
  output logic [NSLOT-1:0][31:0]     rsp_data,
  output logic [REQ_INFOW-1:0]       rsp_info
`ifdef TEX_MEM_SCHED_PERF_EN
  ,
  output logic [31:0]                perf_mem_reqs,
  output logic [31:0]                perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RSP} state_t;

  state_t                  state;
  logic [NSLOT-1:0][31:0]  faddr, slots;
  logic [NSLOT-1:0]        pend, pend_in;
  logic [TAGW:0]           needed, needed_in, rcvd, rcvd_nxt;
  logic [1:0]              lgstride;
  logic [NUM_REQS-1:0]     tmask;
  logic [REQ_INFOW-1:0]    info;
  logic [TAGW-1:0]         cur;
  logic                    mem_fire, last_issue, rsp_cap;
  logic [1:0]              off;
  logic [31:0]             shifted, texel;

  // Slot set for the incoming request; its popcount is the expected response count.
  always_comb begin
    pend_in   = '0;
    needed_in = '0;
    for (int l = 0; l < NUM_REQS; l++)
      for (int t = 0; t < 4; t++)
        pend_in[l*4+t] = req_tmask[l] && (t == 0 || req_filter);
    for (int i = 0; i < NSLOT; i++)
      needed_in = needed_in + (TAGW+1)'(pend_in[i]);
  end

  // Lowest pending slot = lane-major, texel-minor walk order.
  always_comb begin
    cur = '0;
    for (int i = NSLOT-1; i >= 0; i--)
      if (pend[i]) cur = TAGW'(i);
  end

  assign mem_req_valid = (state == ISSUE) && (|pend);
  assign mem_req_addr  = mem_req_valid ? {faddr[cur][31:2], 2'b00} : '0;
  assign mem_req_tag   = mem_req_valid ? cur : '0;
  assign mem_fire      = mem_req_valid && mem_req_ready;
  assign last_issue    = mem_fire && ((pend & (pend - NSLOT'(1))) == '0);
  assign mem_rsp_ready = 1'b1;

  assign rsp_cap  = mem_rsp_valid && (state != IDLE);
  assign rcvd_nxt = rcvd + (TAGW+1)'(rsp_cap);

  // Byte offset of the responding slot selects the texel within the word.
  always_comb begin
    off = '0;
    for (int i = 0; i < NSLOT; i++)
      if (mem_rsp_tag == TAGW'(i)) off = faddr[i][1:0];
    shifted = mem_rsp_data >> {off, 3'b000};
    case (lgstride)
      2'd0:    texel = {24'd0, shifted[7:0]};
      2'd1:    texel = {16'd0, off[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0]};
      default: texel = mem_rsp_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      faddr    <= '0;
      slots    <= '0;
      pend     <= '0;
      needed   <= '0;
      rcvd     <= '0;
      lgstride <= '0;
      tmask    <= '0;
      info     <= '0;
    end else begin
      if (rsp_cap) rcvd <= rcvd_nxt;
      for (int i = 0; i < NSLOT; i++)
        if (rsp_cap && mem_rsp_tag == TAGW'(i)) slots[i] <= texel;
      case (state)
        IDLE: if (req_valid) begin
          for (int i = 0; i < NSLOT; i++)
            faddr[i] <= req_baseaddr[i/4] + req_addr[i];
          slots    <= '0;
          pend     <= pend_in;
          needed   <= needed_in;
          rcvd     <= '0;
          lgstride <= req_lgstride;
          tmask    <= req_tmask;
          info     <= req_info;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (pend == '0) state <= RSP;
          else if (mem_fire) begin
            pend[cur] <= 1'b0;
            if (last_issue) state <= WAIT;
          end
        end
        WAIT:    if (rcvd_nxt == needed) state <= RSP;
        RSP:     if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign rsp_tmask = tmask;
  assign rsp_data  = slots;
  assign rsp_info  = info;

`ifdef TEX_MEM_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_mem_reqs     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (mem_fire) perf_mem_reqs <= perf_mem_reqs + 32'd1;
      if (mem_req_valid && !mem_req_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tex_mem_sched.sv
// Directed bench for tex_mem_sched: point/bilinear fetches, reordered responses, back-pressure, empty mask, reset.
`timescale 1ns/1ps
module tb_tex_mem_sched;
  localparam int NR = 4, NS = 16, TW = 4, IW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_filter, req_ready;
  logic [NR-1:0]     req_tmask;
  logic [1:0]        req_lgstride;
  logic [NR-1:0][31:0] req_baseaddr;
  logic [NS-1:0][31:0] req_addr;
  logic [IW-1:0]     req_info;
  logic              mem_req_valid, mem_req_ready;
  logic [31:0]       mem_req_addr;
  logic [TW-1:0]     mem_req_tag;
  logic              mem_rsp_valid, mem_rsp_ready;
  logic [31:0]       mem_rsp_data;
  logic [TW-1:0]     mem_rsp_tag;
  logic              rsp_valid, rsp_ready;
  logic [NR-1:0]     rsp_tmask;
  logic [NS-1:0][31:0] rsp_data;
  logic [IW-1:0]     rsp_info;
`ifdef TEX_MEM_SCHED_PERF_EN
  logic [31:0]       perf_mem_reqs, perf_stall_cycles;
`endif

  int total = 0, bad = 0;
  bit auto_mem = 1'b0;
  logic          a_valid = 1'b0, m_valid;
  logic [TW-1:0] a_tag = '0, m_tag;
  logic [31:0]   a_data = '0, m_data;
  logic [TW-1:0] q_tag[$];
  logic [31:0]   q_addr[$];

  always #5 clk = ~clk;

  assign mem_rsp_valid = auto_mem ? a_valid : m_valid;
  assign mem_rsp_tag   = auto_mem ? a_tag   : m_tag;
  assign mem_rsp_data  = auto_mem ? a_data  : m_data;

  tex_mem_sched dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_tmask(req_tmask), .req_filter(req_filter),
    .req_lgstride(req_lgstride), .req_baseaddr(req_baseaddr), .req_addr(req_addr),
    .req_info(req_info), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tmask(rsp_tmask),
    .rsp_data(rsp_data), .rsp_info(rsp_info)
`ifdef TEX_MEM_SCHED_PERF_EN
    , .perf_mem_reqs(perf_mem_reqs), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h104) ? 32'hAABB_CCDD : (a ^ 32'h5A5A_0000);
  endfunction

  // Log of every request handshake, in issue order.
  always @(negedge clk)
    if (mem_req_valid && mem_req_ready) begin
      q_tag.push_back(mem_req_tag);
      q_addr.push_back(mem_req_addr);
    end

  // Ideal memory: answers each handshake in the following cycle.
  always begin : responder
    logic f; logic [TW-1:0] t; logic [31:0] a;
    @(negedge clk);
    f = auto_mem && mem_req_valid && mem_req_ready;
    t = mem_req_tag;
    a = mem_req_addr;
    @(posedge clk); #1;
    a_valid = f;
    a_tag   = t;
    a_data  = mem_word(a);
  end

  task automatic send_req(input logic [3:0] tm, input logic fl, input logic [1:0] st,
                          input logic [7:0] inf);
    @(posedge clk); #1;
    req_valid = 1'b1; req_tmask = tm; req_filter = fl; req_lgstride = st; req_info = inf;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // lat = cycle (accept = 0) in which rsp_valid is first seen, -1 on timeout
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total += 9;
    if (req_ready !== 1'b1)     begin bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_req_valid: got %b want 0", mem_req_valid); end
    if (mem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_req_addr: got %h want 0", mem_req_addr); end
    if (mem_req_tag !== '0)     begin bad++; $display("FAIL rst_mem_req_tag: got %h want 0", mem_req_tag); end
    if (mem_rsp_ready !== 1'b1) begin bad++; $display("FAIL rst_mem_rsp_ready: got %b want 1", mem_rsp_ready); end
    if (rsp_valid !== 1'b0)     begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    if (rsp_tmask !== '0)       begin bad++; $display("FAIL rst_rsp_tmask: got %h want 0", rsp_tmask); end
    if (rsp_data !== '0)        begin bad++; $display("FAIL rst_rsp_data: got nonzero want 0"); end
    if (rsp_info !== '0)        begin bad++; $display("FAIL rst_rsp_info: got %h want 0", rsp_info); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_point;
    int lat;
    auto_mem = 1'b1;
    req_baseaddr = '0; req_addr = '0;
    req_baseaddr[0] = 32'h100; req_addr[0] = 32'h6;
    q_tag.delete(); q_addr.delete();
    send_req(4'b0001, 1'b0, 2'd0, 8'h3C);
    wait_rsp(lat);
    total += 5;
    if (lat != 3) begin bad++; $display("FAIL point_latency: got %0d want 3", lat); end
    if (q_tag.size() != 1) begin bad++; $display("FAIL point_nreq: got %0d want 1", q_tag.size()); end
    else begin
      total += 2;
      if (q_tag[0] !== 4'd0)      begin bad++; $display("FAIL point_tag: got %0d want 0", q_tag[0]); end
      if (q_addr[0] !== 32'h104)  begin bad++; $display("FAIL point_addr: got %h want 00000104", q_addr[0]); end
    end
    if (rsp_data[0] !== 32'h0000_00BB) begin bad++; $display("FAIL point_data: got %h want 000000bb", rsp_data[0]); end
    if (rsp_data[1] !== 32'h0)  begin bad++; $display("FAIL point_unreq: got %h want 0", rsp_data[1]); end
    if (rsp_info !== 8'h3C || rsp_tmask !== 4'b0001) begin
      bad++; $display("FAIL point_echo: got info %h mask %b want 3c 0001", rsp_info, rsp_tmask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bilinear;
    int lat;
    int exp_tags[8] = '{0, 1, 2, 3, 8, 9, 10, 11};
    logic [31:0] ea;
    logic [31:0] ed;
    auto_mem = 1'b1;
    req_baseaddr = '{32'h9000, 32'h2000, 32'h9000, 32'h1000};
    for (int i = 0; i < NS; i++) req_addr[i] = 32'(i * 8 + 1);
    q_tag.delete(); q_addr.delete();
    send_req(4'b0101, 1'b1, 2'd2, 8'h5A);
    wait_rsp(lat);
    total++;
    if (lat != 10) begin bad++; $display("FAIL bilin_latency: got %0d want 10", lat); end
    total++;
    if (q_tag.size() != 8) begin bad++; $display("FAIL bilin_nreq: got %0d want 8", q_tag.size()); end
    else
      for (int k = 0; k < 8; k++) begin
        ea = (req_baseaddr[exp_tags[k]/4] + req_addr[exp_tags[k]]) & 32'hFFFF_FFFC;
        total++;
        if (q_tag[k] !== TW'(exp_tags[k]) || q_addr[k] !== ea) begin
          bad++; $display("FAIL bilin_req%0d: got tag %0d addr %h want tag %0d addr %h",
                          k, q_tag[k], q_addr[k], exp_tags[k], ea);
        end
      end
    for (int i = 0; i < NS; i++) begin
      ed = ((i/4) == 0 || (i/4) == 2) ?
           mem_word((req_baseaddr[i/4] + req_addr[i]) & 32'hFFFF_FFFC) : 32'h0;
      total++;
      if (rsp_data[i] !== ed) begin bad++; $display("FAIL bilin_data%0d: got %h want %h", i, rsp_data[i], ed); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_order;
    int order[4] = '{7, 5, 4, 6};
    logic [31:0] words[4] = '{32'hA1A2_B1B2, 32'hC1C2_D1D2, 32'hE1E2_F1F2, 32'h1234_5678};
    logic [31:0] expd[4]  = '{32'h0000_B1B2, 32'h0000_C1C2, 32'h0000_F1F2, 32'h0000_1234};
    bit seen;
    auto_mem = 1'b0; m_valid = 1'b0;
    req_baseaddr = '0; req_addr = '0;
    req_baseaddr[1] = 32'h300;
    req_addr[4] = 32'h0; req_addr[5] = 32'h2; req_addr[6] = 32'h4; req_addr[7] = 32'h6;
    q_tag.delete(); q_addr.delete();
    send_req(4'b0010, 1'b1, 2'd1, 8'hA7);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (q_tag.size() >= 4) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL ooo_issue: got %0d requests want 4", q_tag.size()); end
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      m_valid = 1'b1; m_tag = TW'(order[k]); m_data = words[order[k] - 4];
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL ooo_early%0d: got rsp_valid %b want 0", k, rsp_valid); end
      @(posedge clk); #1;
      m_valid = 1'b0;
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL ooo_rsp_timing: got rsp_valid %b want 1", rsp_valid); end
    for (int s = 0; s < 4; s++) begin
      total++;
      if (rsp_data[s+4] !== expd[s]) begin bad++; $display("FAIL ooo_data%0d: got %h want %h", s+4, rsp_data[s+4], expd[s]); end
    end
    total++;
    if (rsp_data[0] !== 32'h0) begin bad++; $display("FAIL ooo_unreq: got %h want 0", rsp_data[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_pressure;
    int lat;
    logic [31:0] ea;
    logic [31:0] held;
`ifdef TEX_MEM_SCHED_PERF_EN
    logic [31:0] r0, s0;
    r0 = perf_mem_reqs; s0 = perf_stall_cycles;
`endif
    auto_mem = 1'b1; rsp_ready = 1'b0;
    req_addr = '0;
    for (int l = 0; l < NR; l++) begin
      req_baseaddr[l] = 32'h4000 + 32'(l * 256);
      req_addr[l*4]   = 32'(l * 4 + 2);
    end
    ea = (req_baseaddr[1] + req_addr[4]) & 32'hFFFF_FFFC;
    q_tag.delete(); q_addr.delete();
    send_req(4'b1111, 1'b0, 2'd2, 8'h11);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_tag !== 4'd4 || mem_req_addr !== ea || req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d: got v %b tag %0d addr %h rdy %b want 1 4 %h 0",
                        c, mem_req_valid, mem_req_tag, mem_req_addr, req_ready, ea);
      end
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    wait_rsp(lat);
    total++;
    if (lat < 0) begin bad++; $display("FAIL bp_rsp_timeout: got none want rsp_valid"); end
    held = mem_word((req_baseaddr[2] + req_addr[8]) & 32'hFFFF_FFFC);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data[8] !== held || req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_rsp_hold%0d: got v %b data %h rdy %b want 1 %h 0",
                        c, rsp_valid, rsp_data[8], req_ready, held);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      bad++; $display("FAIL bp_pre_hs: got v %b rdy %b want 1 0", rsp_valid, req_ready);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_post_hs: got v %b rdy %b want 0 1", rsp_valid, req_ready);
    end
    total++;
    if (q_tag.size() != 4) begin bad++; $display("FAIL bp_nreq: got %0d want 4", q_tag.size()); end
    else begin
      total++;
      if (q_tag[0] !== 4'd0 || q_tag[1] !== 4'd4 || q_tag[2] !== 4'd8 || q_tag[3] !== 4'd12) begin
        bad++; $display("FAIL bp_tags: got %0d %0d %0d %0d want 0 4 8 12", q_tag[0], q_tag[1], q_tag[2], q_tag[3]);
      end
    end
`ifdef TEX_MEM_SCHED_PERF_EN
    total += 2;
    if (perf_mem_reqs - r0 !== 32'd4) begin bad++; $display("FAIL perf_reqs: got %0d want 4", perf_mem_reqs - r0); end
    if (perf_stall_cycles - s0 !== 32'd5) begin bad++; $display("FAIL perf_stalls: got %0d want 5", perf_stall_cycles - s0); end
`endif
  endtask

  task automatic test_zero_mask;
    int lat;
    auto_mem = 1'b1;
    q_tag.delete(); q_addr.delete();
    send_req(4'b0000, 1'b1, 2'd2, 8'hE5);
    wait_rsp(lat);
    total += 4;
    if (lat != 2) begin bad++; $display("FAIL zero_latency: got %0d want 2", lat); end
    if (rsp_info !== 8'hE5) begin bad++; $display("FAIL zero_info: got %h want e5", rsp_info); end
    if (q_tag.size() != 0) begin bad++; $display("FAIL zero_nreq: got %0d want 0", q_tag.size()); end
    if (rsp_tmask !== 4'b0000 || rsp_data !== '0) begin
      bad++; $display("FAIL zero_out: got mask %b data nonzero=%b want 0000 0", rsp_tmask, |rsp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_wait;
    int lat;
    bit seen;
    auto_mem = 1'b0; m_valid = 1'b0;
    req_baseaddr = '0; req_addr = '0;
    req_baseaddr[0] = 32'h200;
    q_tag.delete(); q_addr.delete();
    send_req(4'b0001, 1'b0, 2'd2, 8'h77);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (q_tag.size() >= 1) seen = 1'b1;
    end
    @(negedge clk);
    total++;
    if (!seen || mem_req_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL rw_in_wait: got issued %b v %b rsp %b rdy %b want 1 0 0 0",
                      seen, mem_req_valid, rsp_valid, req_ready);
    end
    reset = 1'b0;
    #1;
    total += 6;
    if (req_ready !== 1'b1)     begin bad++; $display("FAIL rw_req_ready: got %b want 1", req_ready); end
    if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || mem_req_tag !== '0) begin
      bad++; $display("FAIL rw_mem_req: got %b %h %h want 0 0 0", mem_req_valid, mem_req_addr, mem_req_tag);
    end
    if (mem_rsp_ready !== 1'b1) begin bad++; $display("FAIL rw_mem_rsp_ready: got %b want 1", mem_rsp_ready); end
    if (rsp_valid !== 1'b0)     begin bad++; $display("FAIL rw_rsp_valid: got %b want 0", rsp_valid); end
    if (rsp_tmask !== '0 || rsp_info !== '0) begin
      bad++; $display("FAIL rw_echo: got mask %b info %h want 0 0", rsp_tmask, rsp_info);
    end
    if (rsp_data !== '0)        begin bad++; $display("FAIL rw_rsp_data: got nonzero want 0"); end
    @(posedge clk); #1;
    reset = 1'b1;
    auto_mem = 1'b1;
    req_baseaddr[0] = 32'h100; req_addr[0] = 32'h7;
    send_req(4'b0001, 1'b0, 2'd0, 8'h42);
    wait_rsp(lat);
    total++;
    if (lat != 3 || rsp_data[0] !== 32'h0000_00AA) begin
      bad++; $display("FAIL rw_recover: got lat %0d data %h want 3 000000aa", lat, rsp_data[0]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    req_valid = 1'b0; req_tmask = '0; req_filter = 1'b0; req_lgstride = '0;
    req_baseaddr = '0; req_addr = '0; req_info = '0;
    mem_req_ready = 1'b1; rsp_ready = 1'b1;
    m_valid = 1'b0; m_tag = '0; m_data = '0;
    test_reset;
    test_point;
    test_bilinear;
    test_out_of_order;
    test_back_pressure;
    test_zero_mask;
    test_reset_in_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
